arbitro_alu: RTL and testbench

ARBITRO_ALU -- requirements
Module: arbitro_alu

---
 rtl/alu_pkg.sv | 27 ++
 rtl/arbitro_rr.sv | 42 ++++
 rtl/arbitro_alu.sv | 112 +++++++++++
 tb/tb_arbitro_alu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU arbiter (arbitro_alu and arbitro_rr).
package alu_pkg;

   typedef enum logic [1:0] {
      LIBRE     = 2'd0,
      EMITIR    = 2'd1,
      RESPONDER = 2'd2
   } estado_t;

   localparam int FLAG_N    = 3;
   localparam int FLAG_Z    = 2;
   localparam int FLAG_C    = 1;
   localparam int FLAG_V    = 0;
   localparam int ANCHO_DEF = 3;

   function automatic logic [3:0] empaquetar_flags(input logic n, input logic z,
                                                   input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Two-way arbiter with one-hot grant, gated by an enable.
// ARBITRO_ALU_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise requester 0 wins ties.
module arbitro_rr (
`ifdef ARBITRO_ALU_ROUND_ROBIN_EN
   input  logic       clk,
   input  logic       rst,
`endif
   input  logic [1:0] valido,
   input  logic       habilitar,
   output logic [1:0] concesion
);

`ifdef ARBITRO_ALU_ROUND_ROBIN_EN
   // Requester granted most recently; 1 after reset so requester 0 wins the first tie.
   logic ultimo;

   always_comb begin
      // NOTE: default first so every path assigns concesion and no latch is inferred.
      concesion = 2'b00;
      if (habilitar) begin
         case (valido)
            2'b01:   concesion = 2'b01;
            2'b10:   concesion = 2'b10;
            2'b11:   concesion = ultimo ? 2'b01 : 2'b10;
            default: concesion = 2'b00;
         endcase
      end
   end

   // A grant can only be issued when its requester is valid, so every grant is a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ultimo <= 1'b1;
      else if (|concesion)
         ultimo <= concesion[1];
   end
`else
   assign concesion[0] = habilitar & valido[0];
   assign concesion[1] = habilitar & valido[1] & ~valido[0];
`endif

endmodule

// File: rtl/arbitro_alu.sv
// Arbitrates two requesters onto one external combinational ALU and returns a registered response.
// ARBITRO_ALU_ROUND_ROBIN_EN enables round-robin tie breaking (fixed priority to requester 0 otherwise).
module arbitro_alu
   import alu_pkg::*;
#(
   parameter int ancho = ANCHO_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valido,
   output logic             req0_listo,
   input  logic [ancho:0]   req0_A,
   input  logic [ancho:0]   req0_B,
   input  logic [3:0]       req0_seleccion,
   input  logic             req1_valido,
   output logic             req1_listo,
   input  logic [ancho:0]   req1_A,
   input  logic [ancho:0]   req1_B,
   input  logic [3:0]       req1_seleccion,
   output logic [ancho:0]   alu_A,
   output logic [ancho:0]   alu_B,
   output logic [3:0]       alu_seleccion,
   input  logic [ancho:0]   alu_resultado,
   input  logic             alu_N,
   input  logic             alu_Z,
   input  logic             alu_C,
   input  logic             alu_V,
   output logic             resp_valido,
   input  logic             resp_listo,
   output logic             resp_id,
   output logic [ancho:0]   resp_resultado,
   output logic [3:0]       resp_flags,
   output logic [7:0]       ops_completadas
);

   estado_t        estado;
   logic [1:0]     concesion;
   logic [1:0]     transferencia;
   logic [ancho:0] op_a;
   logic [ancho:0] op_b;
   logic [3:0]     op_sel;
   logic           op_id;

   arbitro_rr u_arbitro (
`ifdef ARBITRO_ALU_ROUND_ROBIN_EN
      .clk       (clk),
      .rst       (rst),
`endif
      .valido    ({req1_valido, req0_valido}),
      .habilitar (estado == LIBRE),
      .concesion (concesion)
   );

   assign req0_listo    = concesion[0];
   assign req1_listo    = concesion[1];
   assign transferencia = concesion & {req1_valido, req0_valido};

   assign alu_A         = op_a;
   assign alu_B         = op_b;
   assign alu_seleccion = op_sel;

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado          <= LIBRE;
         op_a            <= '0;
         op_b            <= '0;
         op_sel          <= '0;
         op_id           <= 1'b0;
         resp_valido     <= 1'b0;
         resp_id         <= 1'b0;
         resp_resultado  <= '0;
         resp_flags      <= '0;
         ops_completadas <= '0;
      end else begin
         case (estado)
            LIBRE: begin
               if (transferencia[0]) begin
                  op_a   <= req0_A;
                  op_b   <= req0_B;
                  op_sel <= req0_seleccion;
                  op_id  <= 1'b0;
                  estado <= EMITIR;
               end else if (transferencia[1]) begin
                  op_a   <= req1_A;
                  op_b   <= req1_B;
                  op_sel <= req1_seleccion;
                  op_id  <= 1'b1;
                  estado <= EMITIR;
               end
            end
            // The ALU has had a full cycle to settle on the held operands.
            EMITIR: begin
               resp_resultado <= alu_resultado;
               resp_flags     <= empaquetar_flags(alu_N, alu_Z, alu_C, alu_V);
               resp_id        <= op_id;
               resp_valido    <= 1'b1;
               estado         <= RESPONDER;
            end
            RESPONDER: begin
               if (resp_listo) begin
                  resp_valido     <= 1'b0;
                  ops_completadas <= ops_completadas + 8'd1;
                  estado          <= LIBRE;
               end
            end
            default: estado <= LIBRE;
         endcase
      end
   end

endmodule

// File: tb/tb_arbitro_alu.sv
// Self-checking bench for arbitro_alu; the bench drives the ALU result/flag inputs itself.
module tb_arbitro_alu;
   import alu_pkg::*;

   localparam int ANCHO = 3;
   localparam int W     = ANCHO + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valido, req0_listo, req1_valido, req1_listo;
   logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
   logic [3:0]   req0_seleccion, req1_seleccion;
   logic [W-1:0] alu_A, alu_B, alu_resultado;
   logic [3:0]   alu_seleccion;
   logic         alu_N, alu_Z, alu_C, alu_V;
   logic         resp_valido, resp_listo, resp_id;
   logic [W-1:0] resp_resultado;
   logic [3:0]   resp_flags;
   logic [7:0]   ops_completadas;

   typedef struct {
      logic         id;
      logic [W-1:0] res;
      logic [3:0]   flags;
   } esperado_t;

   esperado_t  sb[$];
   int         pasa  = 0;
   int         total = 0;
   logic [7:0] ops_modelo = 8'd0;
   logic [3:0] tie_exp;

   always #5 clk = ~clk;

   arbitro_alu #(.ancho(ANCHO)) dut (
      .clk             (clk),
      .rst             (rst),
      .req0_valido     (req0_valido),
      .req0_listo      (req0_listo),
      .req0_A          (req0_A),
      .req0_B          (req0_B),
      .req0_seleccion  (req0_seleccion),
      .req1_valido     (req1_valido),
      .req1_listo      (req1_listo),
      .req1_A          (req1_A),
      .req1_B          (req1_B),
      .req1_seleccion  (req1_seleccion),
      .alu_A           (alu_A),
      .alu_B           (alu_B),
      .alu_seleccion   (alu_seleccion),
      .alu_resultado   (alu_resultado),
      .alu_N           (alu_N),
      .alu_Z           (alu_Z),
      .alu_C           (alu_C),
      .alu_V           (alu_V),
      .resp_valido     (resp_valido),
      .resp_listo      (resp_listo),
      .resp_id         (resp_id),
      .resp_resultado  (resp_resultado),
      .resp_flags      (resp_flags),
      .ops_completadas (ops_completadas)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pasa++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operation and wait for its grant; returns in the EMITIR cycle.
   task automatic lanzar(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] sel, input logic [W-1:0] res, input logic [3:0] flg);
      esperado_t e;
      int        n;
      alu_resultado = res;
      {alu_N, alu_Z, alu_C, alu_V} = flg;
      if (id) begin
         req1_valido = 1'b1; req1_A = a; req1_B = b; req1_seleccion = sel;
      end else begin
         req0_valido = 1'b1; req0_A = a; req0_B = b; req0_seleccion = sel;
      end
      #1;
      n = 0;
      while (!(id ? req1_listo : req0_listo) && n < 20) begin
         tick();
         n++;
      end
      check("grant_wait", 32'(n < 20), 32'd1);
      check("other_listo", 32'(id ? req0_listo : req1_listo), 32'd0);
      e.id = id; e.res = res; e.flags = flg;
      sb.push_back(e);
      tick();
      if (id) req1_valido = 1'b0; else req0_valido = 1'b0;
      check("emit_alu_A", 32'(alu_A), 32'(a));
      check("emit_alu_B", 32'(alu_B), 32'(b));
      check("emit_alu_sel", 32'(alu_seleccion), 32'(sel));
      check("emit_resp_valido", 32'(resp_valido), 32'd0);
      check("emit_listo", 32'({req1_listo, req0_listo}), 32'd0);
   endtask

   // Response phase: must appear the cycle after EMITIR; optionally stall it before accepting.
   task automatic recibir(input int retener);
      esperado_t e;
      tick();
      check("resp_valido_t2", 32'(resp_valido), 32'd1);
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         for (int i = 0; i < retener; i++) begin
            resp_listo = 1'b0;
            tick();
            check("hold_valido", 32'(resp_valido), 32'd1);
            check("hold_resultado", 32'(resp_resultado), 32'(e.res));
            check("hold_listo", 32'({req1_listo, req0_listo}), 32'd0);
         end
         check("resp_id", 32'(resp_id), 32'(e.id));
         check("resp_resultado", 32'(resp_resultado), 32'(e.res));
         check("resp_flags", 32'(resp_flags), 32'(e.flags));
      end
      req0_valido = 1'b0;
      req1_valido = 1'b0;
      resp_listo  = 1'b1;
      tick();
      resp_listo = 1'b0;
      ops_modelo = ops_modelo + 8'd1;
      check("ops_completadas", 32'(ops_completadas), 32'(ops_modelo));
      check("resp_valido_drop", 32'(resp_valido), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      esperado_t e;
`ifdef ARBITRO_ALU_ROUND_ROBIN_EN
      tie_exp = 4'b1010;
`else
      tie_exp = 4'b0000;
`endif
      rst = 1'b1;
      req0_valido = 1'b0; req1_valido = 1'b0; resp_listo = 1'b0;
      req0_A = '0; req0_B = '0; req0_seleccion = '0;
      req1_A = '0; req1_B = '0; req1_seleccion = '0;
      alu_resultado = '0; {alu_N, alu_Z, alu_C, alu_V} = 4'b0000;
      tick();
      tick();
      check("rst_resp_valido", 32'(resp_valido), 32'd0);
      check("rst_alu_A", 32'(alu_A), 32'd0);
      check("rst_ops", 32'(ops_completadas), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      rst = 1'b0;
      tick();

      // Single operation: 3 + 5 = 8, flags clear.
      lanzar(1'b0, 4'd3, 4'd5, 4'b0000, 4'd8, 4'b0000);
      recibir(0);

      // Flags capture: result 0 with Z and C set.
      lanzar(1'b0, 4'd9, 4'd7, 4'b0001, 4'd0, 4'b0110);
      recibir(0);

      // Backpressure from requester 1 while requester 0 contends.
      lanzar(1'b1, 4'd7, 4'd1, 4'b0001, 4'd6, 4'b0000);
      req0_valido = 1'b1;
      req0_A = 4'd1; req0_B = 4'd1; req0_seleccion = 4'b0000;
      recibir(5);
      req0_valido = 1'b1;
      #1;
      check("libre_after_accept", 32'(req0_listo), 32'd1);
      req0_valido = 1'b0;
      tick();

      // Continuous tie with the consumer always ready.
      req0_A = 4'd2; req0_B = 4'd2; req0_seleccion = 4'b0000;
      req1_A = 4'd4; req1_B = 4'd1; req1_seleccion = 4'b0001;
      alu_resultado = 4'hA; {alu_N, alu_Z, alu_C, alu_V} = 4'b1000;
      req0_valido = 1'b1; req1_valido = 1'b1; resp_listo = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("tie_onehot", 32'(req0_listo) + 32'(req1_listo), 32'd1);
         check("tie_grant", 32'(req1_listo), 32'(tie_exp[k]));
         e.id = tie_exp[k]; e.res = 4'hA; e.flags = 4'b1000;
         sb.push_back(e);
         tick();
         tick();
         check("tie_resp_valido", 32'(resp_valido), 32'd1);
         e = sb.pop_front();
         check("tie_resp_id", 32'(resp_id), 32'(e.id));
         check("tie_resp_res", 32'(resp_resultado), 32'(e.res));
         tick();
         ops_modelo = ops_modelo + 8'd1;
      end
      req0_valido = 1'b0; req1_valido = 1'b0; resp_listo = 1'b0;
      check("tie_ops", 32'(ops_completadas), 32'(ops_modelo));

      // Reset while in EMITIR discards the operation.
      lanzar(1'b1, 4'd2, 4'd3, 4'b0011, 4'd5, 4'b0001);
      rst = 1'b1;
      #1;
      check("mid_rst_valido", 32'(resp_valido), 32'd0);
      check("mid_rst_alu_A", 32'(alu_A), 32'd0);
      check("mid_rst_alu_B", 32'(alu_B), 32'd0);
      check("mid_rst_alu_sel", 32'(alu_seleccion), 32'd0);
      check("mid_rst_resp_res", 32'(resp_resultado), 32'd0);
      check("mid_rst_ops", 32'(ops_completadas), 32'd0);
      sb.delete();
      ops_modelo = 8'd0;
      tick();
      rst = 1'b0;
      resp_listo = 1'b1;
      tick();
      tick();
      tick();
      check("post_rst_no_resp", 32'(resp_valido), 32'd0);
      check("post_rst_ops", 32'(ops_completadas), 32'd0);
      resp_listo = 1'b0;
      req0_valido = 1'b1; req1_valido = 1'b1;
      #1;
      check("post_rst_tie_req0", 32'(req0_listo), 32'd1);
      check("post_rst_tie_req1", 32'(req1_listo), 32'd0);
      req0_valido = 1'b0; req1_valido = 1'b0;
      tick();

      // Counter wrap: back-to-back operations every 3 cycles.
      req0_valido = 1'b1; resp_listo = 1'b1;
      repeat (255 * 3) tick();
      check("ops_255", 32'(ops_completadas), 32'd255);
      repeat (3) tick();
      check("ops_wrap", 32'(ops_completadas), 32'd0);
      req0_valido = 1'b0; resp_listo = 1'b0;
      tick();

      $display("%0d/%0d checks passed", pasa, total);
      $finish;
   end

endmodule
